// File: rtl/ring_slot_sequencer_if.sv
// ring_slot_sequencer_if
// Purpose: groups the two byte-wide requester ports (A and B) of the ring
//          slot sequencer into one bundle.
// Signals (per requester x = a/b):
//   req_x   requester -> sequencer  request, held high until done
//   we_x    requester -> sequencer  1 = write, 0 = read (sampled at grant)
//   addr_x  requester -> sequencer  word index (sampled at grant)
//   wdata_x requester -> sequencer  write byte (sampled at grant)
//   gnt_x   sequencer -> requester  one-cycle grant pulse
//   done_x  sequencer -> requester  one-cycle completion pulse
//   rdata_x sequencer -> requester  previous word contents
// Modports: master = requester side, slave = sequencer side.
interface ring_slot_sequencer_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              req_a;
  logic              req_b;
  logic              we_a;
  logic              we_b;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic [7:0]        wdata_a;
  logic [7:0]        wdata_b;
  logic              gnt_a;
  logic              gnt_b;
  logic              done_a;
  logic              done_b;
  logic [7:0]        rdata_a;
  logic [7:0]        rdata_b;

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  gnt_a, gnt_b, done_a, done_b, rdata_a, rdata_b
  );

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output gnt_a, gnt_b, done_a, done_b, rdata_a, rdata_b
  );
endinterface

// File: rtl/ring_slot_sequencer.sv
// ring_slot_sequencer
// Purpose: byte-access controller for a circulating serial ring memory of
//          WORD_COUNT bytes. Tracks ring rotation, arbitrates requesters A/B,
//          drives the ring write strobe/data during the granted word's 8-cycle
//          slot and captures the word's previous contents (swap semantics).
// Ports:
//   clk          ring and controller clock (ring rotates one bit per cycle)
//   reset        asynchronous, active-high, shared with the ring
//   bus          requester bundle (slave modport), see ring_slot_sequencer_if
//   o_busy       high whenever the FSM is not IDLE
//   o_ring_wr    1 = ring shifts in o_ring_din, 0 = ring recirculates
//   o_ring_din   serial write bit
//   i_ring_dout  ring bit currently being recirculated (ring MSB)
// Configuration macro:
//   RING_SEQ_RR_EN  defined: round-robin priority (A first after reset)
//                   undefined: fixed priority, A always beats B
module ring_slot_sequencer #(
  parameter int unsigned WORD_COUNT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  ring_slot_sequencer_if.slave  bus,
  output logic                  o_busy,
  output logic                  o_ring_wr,
  output logic                  o_ring_din,
  input  logic                  i_ring_dout
);

  localparam int unsigned ADDR_W = $clog2(WORD_COUNT);
  localparam int unsigned POS_W  = $clog2(WORD_COUNT * 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEEK = 2'd1,
    S_XFER = 2'd2,
    S_ACK  = 2'd3
  } state_t;

  state_t            r_state;
  logic [POS_W-1:0]  r_pos;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wdata;
  logic              r_sel_b;
  logic [7:0]        r_cap;
  logic              r_done_a;
  logic              r_done_b;
  logic [7:0]        r_rdata_a;
  logic [7:0]        r_rdata_b;
  logic              r_busy;
  logic              r_ring_wr;
  logic              r_ring_din;
`ifdef RING_SEQ_RR_EN
  logic              r_prio_b;
`endif

  logic [POS_W-1:0]  w_pos_nxt;
  logic              w_pick_b;
  logic              w_grant;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [7:0]        w_sel_wdata;
  logic [POS_W-1:0]  w_target;
  logic              w_hit;
  logic [2:0]        w_bit_nxt;

  // Ring position of the next cycle; the ring rotates unconditionally.
  assign w_pos_nxt = r_pos + POS_W'(1);

  // Arbitration between the two requesters.
`ifdef RING_SEQ_RR_EN
  assign w_pick_b = bus.req_b & (~bus.req_a | r_prio_b);
`else
  assign w_pick_b = bus.req_b & ~bus.req_a;
`endif

  // Grant is decoded in the IDLE cycle itself so a requester that drops req
  // right after done is never granted again; suppressed while in reset.
  assign w_grant = (r_state == S_IDLE) & (bus.req_a | bus.req_b) & ~reset;

  assign w_sel_we    = w_pick_b ? bus.we_b    : bus.we_a;
  assign w_sel_addr  = w_pick_b ? bus.addr_b  : bus.addr_a;
  assign w_sel_wdata = w_pick_b ? bus.wdata_b : bus.wdata_a;

  // Slot start for the transaction that will be active next cycle.
  assign w_target = (r_state == S_IDLE) ? {w_sel_addr, 3'b000} : {r_addr, 3'b000};
  assign w_hit    = (w_pos_nxt == w_target);

  // Bit of wdata to drive on the next XFER cycle (k+1 -> bit 6-k).
  assign w_bit_nxt = 3'd6 - r_pos[2:0];

  // Controller FSM. Ring strobes are registered one cycle ahead so they line
  // up exactly with the slot; the match cycle itself is XFER k=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pos      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_sel_b    <= 1'b0;
      r_cap      <= '0;
      r_done_a   <= 1'b0;
      r_done_b   <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
      r_busy     <= 1'b0;
      r_ring_wr  <= 1'b0;
      r_ring_din <= 1'b0;
`ifdef RING_SEQ_RR_EN
      r_prio_b   <= 1'b0;
`endif
    end else begin
      r_pos      <= w_pos_nxt;
      r_done_a   <= 1'b0;
      r_done_b   <= 1'b0;
      r_ring_wr  <= 1'b0;
      r_ring_din <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_sel_b <= w_pick_b;
            r_busy  <= 1'b1;
`ifdef RING_SEQ_RR_EN
            r_prio_b <= ~w_pick_b;
`endif
            if (w_hit) begin
              r_state    <= S_XFER;
              r_ring_wr  <= w_sel_we;
              r_ring_din <= w_sel_we & w_sel_wdata[7];
            end else begin
              r_state <= S_SEEK;
            end
          end
        end

        S_SEEK: begin
          if (w_hit) begin
            r_state    <= S_XFER;
            r_ring_wr  <= r_we;
            r_ring_din <= r_we & r_wdata[7];
          end
        end

        S_XFER: begin
          // Capture previous contents MSB first while the slot passes by.
          r_cap <= {r_cap[6:0], i_ring_dout};
          if (r_pos[2:0] == 3'd7) begin
            r_state <= S_ACK;
            if (r_sel_b) begin
              r_done_b  <= 1'b1;
              r_rdata_b <= {r_cap[6:0], i_ring_dout};
            end else begin
              r_done_a  <= 1'b1;
              r_rdata_a <= {r_cap[6:0], i_ring_dout};
            end
          end else begin
            r_ring_wr  <= r_we;
            r_ring_din <= r_we & r_wdata[w_bit_nxt];
          end
        end

        S_ACK: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_a   = w_grant & ~w_pick_b;
  assign bus.gnt_b   = w_grant & w_pick_b;
  assign bus.done_a  = r_done_a;
  assign bus.done_b  = r_done_b;
  assign bus.rdata_a = r_rdata_a;
  assign bus.rdata_b = r_rdata_b;
  assign o_busy      = r_busy;
  assign o_ring_wr   = r_ring_wr;
  assign o_ring_din  = r_ring_din;

endmodule
